// File: rtl/vsa_mem_responder_if.sv
// Core and loader bus between the VSA core and its memory responder.
// master = core/loader side, slave = responder side.
interface vsa_mem_responder_if;
   logic [4:0]  PC;
   logic [11:0] instruction;
   logic [4:0]  ALUOutput;
   logic [4:0]  dataout;
   logic        wr;
   logic [4:0]  datain;
   logic        ld_valid;
   logic        ld_ready;
   logic        ld_sel;
   logic [4:0]  ld_addr;
   logic [11:0] ld_data;

   modport master (
      output PC, ALUOutput, dataout, wr,
      output ld_valid, ld_sel, ld_addr, ld_data,
      input  instruction, datain, ld_ready
   );

   modport slave (
      input  PC, ALUOutput, dataout, wr,
      input  ld_valid, ld_sel, ld_addr, ld_data,
      output instruction, datain, ld_ready
   );
endinterface

// File: rtl/vsa_mem_responder.sv
// Memory responder for the 12-bit VSA core: instruction store, data store,
// phase tracking so fetches land in IF, and a valid/ready preload port.
//
// state   | meaning
// PH_IF   | core samples instruction
// PH_ID   | decode
// PH_EX   | execute, ALUOutput settling
// PH_MEM  | data access, wr may be asserted
// PH_WB   | writeback, PC stable; fetch edge ends this phase
module vsa_mem_responder #(
   parameter int          IMEM_DEPTH = 32,
   parameter int          DMEM_DEPTH = 32,
   parameter logic [11:0] IRESET     = 12'h000
) (
   input  logic                clock,
   input  logic                reset_n,
   vsa_mem_responder_if.slave  bus,
   output logic [2:0]          phase,
   output logic                misalign,
   output logic [7:0]          st_count
);

   typedef enum logic [2:0] {
      PH_IF  = 3'd0,
      PH_ID  = 3'd1,
      PH_EX  = 3'd2,
      PH_MEM = 3'd3,
      PH_WB  = 3'd4
   } phaseState;

   phaseState   state;
   logic [11:0] imem [IMEM_DEPTH];
   logic [4:0]  dmem [DMEM_DEPTH];
   logic        ldFire;

   // Core store owns the data store; the fetch edge owns the instruction store.
   assign bus.ld_ready = !((bus.ld_sel && bus.wr) ||
                           (!bus.ld_sel && (state == PH_WB)));
   assign ldFire       = bus.ld_valid && bus.ld_ready;

   assign bus.datain = dmem[bus.ALUOutput];
   assign phase      = state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= PH_IF;
         bus.instruction <= IRESET;
         misalign        <= 1'b0;
         st_count        <= 8'h00;
      end else begin
         case (state)
            PH_IF:   state <= PH_ID;
            PH_ID:   state <= PH_EX;
            PH_EX:   state <= PH_MEM;
            PH_MEM:  state <= PH_WB;
            PH_WB:   state <= PH_IF;
            default: state <= PH_IF;
         endcase

         if (state == PH_WB) begin
            bus.instruction <= imem[bus.PC];
            if (bus.PC[0])
               misalign <= 1'b1;
         end

         if (bus.wr && (st_count != 8'hFF))
            st_count <= st_count + 8'd1;
      end
   end

   // Storage is deliberately left out of reset so a preloaded program survives it.
   always_ff @(posedge clock) begin
      if (ldFire && !bus.ld_sel)
         imem[bus.ld_addr] <= bus.ld_data;

      if (bus.wr)
         dmem[bus.ALUOutput] <= bus.dataout;
      else if (ldFire && bus.ld_sel)
         dmem[bus.ld_addr] <= bus.ld_data[4:0];
   end

endmodule

// File: tb/tb_vsa_mem_responder.sv
// Directed bench for vsa_mem_responder: fetch timing, loader arbitration,
// store counting, misalign stickiness and asynchronous reset.
module tb_vsa_mem_responder;
   logic       clock;
   logic       reset_n;
   logic [2:0] phase;
   logic       misalign;
   logic [7:0] st_count;
   logic [2:0] tbPhase;
   int         nChecks;
   int         nErrors;
   int         waits;

   vsa_mem_responder_if bus();

   vsa_mem_responder dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .bus      (bus),
      .phase    (phase),
      .misalign (misalign),
      .st_count (st_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference phase: 0..4 ring, cleared by reset.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         tbPhase <= 3'd0;
      else
         tbPhase <= (tbPhase == 3'd4) ? 3'd0 : tbPhase + 3'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called just after a negedge; returns at the negedge after the transfer.
   task automatic loadWord(input logic sel, input logic [4:0] addr,
                           input logic [11:0] data, output int nWait);
      logic expFirst;
      nWait        = 0;
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_addr  = addr;
      bus.ld_data  = data;
      #1;
      expFirst = !((sel && bus.wr) || (!sel && tbPhase == 3'd4));
      chk("ld_ready_first", bus.ld_ready, expFirst);
      while (!bus.ld_ready && nWait < 10) begin
         @(negedge clock);
         #1;
         nWait++;
      end
      chk("ld_accept", bus.ld_ready, 1'b1);
      @(negedge clock);
      bus.ld_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nChecks       = 0;
      nErrors       = 0;
      reset_n       = 1'b0;
      bus.PC        = 5'd0;
      bus.ALUOutput = 5'd0;
      bus.dataout   = 5'd0;
      bus.wr        = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.ld_sel    = 1'b0;
      bus.ld_addr   = 5'd0;
      bus.ld_data   = 12'd0;

      step(3);
      chk("rst_phase", phase, 3'd0);
      chk("rst_instr", bus.instruction, 12'h000);
      chk("rst_misalign", misalign, 1'b0);
      chk("rst_st_count", st_count, 8'h00);

      reset_n = 1'b1;
      loadWord(1'b1, 5'd5, 12'h013, waits);
      chk("ld_dmem_wait", waits, 0);
      bus.ALUOutput = 5'd5;
      #1;
      chk("dmem5_raw", bus.datain, 5'h13);
      loadWord(1'b1, 5'd7, 12'h004, waits);
      loadWord(1'b0, 5'd0, 12'h608, waits);
      loadWord(1'b0, 5'd2, 12'h810, waits);

      // Re-align to IF with the program already loaded.
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      bus.PC  = 5'd0;
      chk("fetch_pre_if", bus.instruction, 12'h000);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk("fetch_hold_reset", bus.instruction, 12'h000);
         chk("phase_track", phase, tbPhase);
      end
      step(1);
      chk("fetch_pc0", bus.instruction, 12'h608);
      chk("phase_wrap", phase, 3'd0);
      bus.PC = 5'd2;
      step(4);
      chk("fetch_hold", bus.instruction, 12'h608);
      step(1);
      chk("fetch_pc2", bus.instruction, 12'h810);

      // Instruction-store load blocked in WB, accepted in IF, seen by next fetch.
      step(4);
      chk("phase_wb", phase, 3'd4);
      loadWord(1'b0, 5'd2, 12'h3C5, waits);
      chk("ld_imem_wb_wait", waits, 1);
      step(3);
      chk("collide_old", bus.instruction, 12'h810);
      step(1);
      chk("collide_new", bus.instruction, 12'h3C5);

      // Core store in MEM beats a data-store load.
      step(3);
      chk("phase_mem", phase, 3'd3);
      bus.wr        = 1'b1;
      bus.ALUOutput = 5'd7;
      bus.dataout   = 5'h1A;
      #1;
      chk("store_same_cycle_old", bus.datain, 5'h04);
      fork
         loadWord(1'b1, 5'd9, 12'h015, waits);
         begin
            @(negedge clock);
            bus.wr = 1'b0;
         end
      join
      chk("ld_after_store_wait", waits, 1);
      chk("st_count_one", st_count, 8'h01);
      bus.ALUOutput = 5'd7;
      #1;
      chk("store_dmem7", bus.datain, 5'h1A);
      bus.ALUOutput = 5'd9;
      #1;
      chk("ld_dmem9", bus.datain, 5'h15);

      // Sticky misalign.
      chk("phase_if_again", phase, tbPhase);
      bus.PC = 5'h03;
      step(4);
      chk("misalign_before", misalign, 1'b0);
      step(1);
      chk("misalign_set", misalign, 1'b1);
      bus.PC = 5'd0;
      step(7);
      chk("misalign_sticky", misalign, 1'b1);

      // Store counter saturation.
      bus.wr        = 1'b1;
      bus.ALUOutput = 5'd20;
      bus.dataout   = 5'h0F;
      step(253);
      chk("st_count_254", st_count, 8'hFE);
      step(47);
      chk("st_count_sat", st_count, 8'hFF);
      bus.wr = 1'b0;
      #1;
      chk("store_dmem20", bus.datain, 5'h0F);

      // Asynchronous reset in the middle of EX.
      for (int k = 0; k < 6 && tbPhase != 3'd2; k++)
         step(1);
      chk("phase_ex", phase, 3'd2);
      chk("instr_before_reset", bus.instruction, 12'h608);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_phase", phase, 3'd0);
      chk("async_instr", bus.instruction, 12'h000);
      chk("async_misalign", misalign, 1'b0);
      chk("async_st_count", st_count, 8'h00);
      step(1);
      reset_n = 1'b1;
      step(5);
      chk("imem_survives_reset", bus.instruction, 12'h608);
      chk("misalign_clear", misalign, 1'b0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/vsa_mem_responder.md
Name: vsa_mem_responder

Overview:
- Memory-side responder for the 12-bit very simple architecture core: instruction store (32 x 12) and data store (32 x 5).
- Answers the core's instruction fetches (PC -> instruction) and data accesses (ALUOutput/dataout/wr -> datain).
- Tracks the core's fixed 5-phase cycle, so the fetched instruction is valid during the core's IF phase.
- Provides a valid/ready loader port for preloading program and data, with arbitration against core writes.

Parameters:
- IMEM_DEPTH, 32, instruction words; indexed by the 5-bit PC.
- DMEM_DEPTH, 32, data words; indexed by the 5-bit ALUOutput.
- IRESET, 12'h000, value of instruction after reset (opcode LW, R0 <- mem[0+0], harmless).

Ports:
- clock  in  1  master clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- PC  in  5  instruction address from core.
- instruction  out  12  registered instruction word to core.
- ALUOutput  in  5  data address from core.
- dataout  in  5  store data from core.
- wr  in  1  store strobe from core; asserted only in MEM phase.
- datain  out  5  load data to core (combinational read).
- ld_valid  in  1  loader request.
- ld_ready  out  1  loader accept.
- ld_sel  in  1  0 = instruction store, 1 = data store.
- ld_addr  in  5  loader address.
- ld_data  in  12  loader data; data store uses bits [4:0].
- phase  out  3  responder's copy of the core phase (0 IF, 1 ID, 2 EX, 3 MEM, 4 WB).
- misalign  out  1  sticky: PC[0]=1 seen at the instruction fetch point.
- st_count  out  8  count of core stores, saturating.

Behaviour:
- Reset (reset_n low, asynchronous):
  - phase=0, instruction=IRESET, misalign=0, st_count=0.
  - Storage contents are not reset.
  - Reset is released in step with the core's reset so both start at IF.
- Phase counter:
  - Sequence 0->1->2->3->4->0; advances every clock.
  - Values 5-7 are unreachable; if ever seen, next value is 0.
- Instruction read:
  - On the edge that ends phase 4 (WB): instruction <= imem[PC]. The core updates PC at the end of MEM, so PC is stable in WB.
  - The register holds through phases 0-3.
  - Net effect: the core samples imem[PC] in IF with no bubbles.
- misalign: set on the same edge if PC[0]=1; cleared only by reset.
- Data read: datain = dmem[ALUOutput], combinational (asynchronous read). It is valid in MEM, when ALUOutput is stable.
- Core store:
  - When wr=1 on a rising edge: dmem[ALUOutput] <= dataout.
  - st_count increments by 1 and saturates at 255.
  - wr is honoured in any phase; the core asserts it only in MEM.
- Loader handshake:
  - A transfer occurs on an edge where ld_valid & ld_ready are both 1.
  - ld_sel=0: imem[ld_addr] <= ld_data.
  - ld_sel=1: dmem[ld_addr] <= ld_data[4:0].
  - ld_ready is combinational:
    - ld_ready=0 when ld_sel=1 and wr=1 (core store has priority on the data store).
    - ld_ready=0 when ld_sel=0 and phase=4 (instruction fetch edge).
    - ld_ready=1 otherwise.
  - The requester holds ld_valid/ld_sel/ld_addr/ld_data stable until accepted.
- Instruction-store collision: a loader write to address PC is accepted in phases 0-3 and is seen by the next fetch.
- Read-after-write: a loader write or core store to dmem[a] is visible on datain in the following cycle; same-cycle datain shows the old value.
- Widths: all addresses are 5 bits and wrap naturally. No arithmetic beyond the phase counter and st_count.

Test Plan:
- Reset released, imem[0]=12'h608, imem[2]=12'h810 preloaded -> instruction=12'h000 through the first IF; after the WB edge with PC=0, instruction=12'h608; with PC=2 at the next WB, 12'h810.
- Loader ld_sel=1, addr=5, data=12'h013 while idle -> ld_ready=1, accepted in 1 cycle; next cycle with ALUOutput=5, datain=5'h13.
- In MEM phase, wr=1, ALUOutput=7, dataout=5'h1A, with a simultaneous loader ld_sel=1 -> ld_ready=0; dmem[7]=5'h1A; loader accepted the following cycle; st_count=1.
- Loader ld_sel=0 held valid entering phase 4 -> ld_ready=0 in phase 4; accepted in phase 0.
- PC=5'h03 presented in WB -> misalign=1 after that edge and remains 1 across further cycles until reset_n pulses low.
- 300 wr pulses -> st_count saturates at 8'hFF. reset_n asserted mid-phase 2 -> phase=0 and instruction=12'h000 immediately, without waiting for a clock edge.
